// File: rtl/aes_ctr_ctrl.sv
// ---------------------------------------------------------------------------
// aes_ctr_ctrl
//   Sequencer that drives one aes_core instance in CTR mode for a streaming
//   data path. It loads the AES-256 key and initial counter block, strobes
//   the core, XORs each keystream block with one input block and presents
//   the result on a valid/ready output. After each block it increments the
//   low CTR_W bits of the counter block.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both 1. A source holds valid and data stable until that edge. The
//   sink may raise or lower ready at any time. s_ready is combinational.
//   m_valid/m_data are registered and held until m_ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_key/iv/load     key + initial counter block, strobe to load them
//   key_ready           key expanded, stream accepted
//   ctr_wrap            sticky: counter field wrapped, stream blocked
//   err_timeout         sticky: core did not respond within TIMEOUT cycles
//   s_data/valid/ready  input block stream
//   m_data/valid/ready  output block stream (s_data ^ keystream)
//   core_*              connection to aes_core
//   dbg_state           current FSM state, for observation only
// ---------------------------------------------------------------------------
module aes_ctr_ctrl #(
    parameter int CTR_W   = 32,
    parameter int TIMEOUT = 127
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] cfg_key,
    input  logic [127:0] cfg_iv,
    input  logic         cfg_load,
    output logic         key_ready,
    output logic         ctr_wrap,
    output logic         err_timeout,
    input  logic [127:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [127:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [255:0] core_key,
    output logic         core_key_valid,
    output logic [127:0] core_plaintext,
    output logic         core_encrypt_start,
    output logic         core_clear,
    input  logic         core_ready,
    input  logic         core_done,
    input  logic [127:0] core_ciphertext,
    output logic [2:0]   dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_KEYLOAD = 3'd1;
    localparam logic [2:0] S_KEYWAIT = 3'd2;
    localparam logic [2:0] S_WAIT_IN = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;

    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [TW-1:0] tmo_cnt;
    logic [127:0]  ctr;
    logic [127:0]  ctr_next;
    logic [127:0]  data_q;
    logic          load_ok;

    // A load is only taken while nothing is in flight.
    assign load_ok = cfg_load && (state == S_IDLE || state == S_WAIT_IN);

    // cfg_load takes priority over an input block in the same cycle.
    assign s_ready = (state == S_WAIT_IN) && core_ready && !ctr_wrap &&
                     !err_timeout && !cfg_load;

    // Only the low CTR_W bits count; the nonce part above is left untouched.
    always_comb begin
        ctr_next              = ctr;
        ctr_next[CTR_W-1:0]   = ctr[CTR_W-1:0] + 1'b1;
    end

    assign core_plaintext = ctr;
    assign dbg_state      = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            tmo_cnt            <= '0;
            ctr                <= '0;
            data_q             <= '0;
            key_ready          <= 1'b0;
            ctr_wrap           <= 1'b0;
            err_timeout        <= 1'b0;
            m_data             <= '0;
            m_valid            <= 1'b0;
            core_key           <= '0;
            core_key_valid     <= 1'b0;
            core_encrypt_start <= 1'b0;
            core_clear         <= 1'b0;
        end else begin
            core_key_valid     <= 1'b0;
            core_encrypt_start <= 1'b0;
            core_clear         <= 1'b0;

            if (load_ok) begin
                core_key       <= cfg_key;
                ctr            <= cfg_iv;
                ctr_wrap       <= 1'b0;
                err_timeout    <= 1'b0;
                key_ready      <= 1'b0;
                core_key_valid <= 1'b1;
                state          <= S_KEYLOAD;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_KEYLOAD: begin
                        tmo_cnt <= '0;
                        state   <= S_KEYWAIT;
                    end
                    S_KEYWAIT: begin
                        if (core_ready) begin
                            key_ready <= 1'b1;
                            state     <= S_WAIT_IN;
                        end else if (tmo_cnt == TMO_LAST) begin
                            err_timeout <= 1'b1;
                            key_ready   <= 1'b0;
                            core_clear  <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_WAIT_IN: begin
                        if (s_valid && s_ready) begin
                            data_q             <= s_data;
                            core_encrypt_start <= 1'b1;
                            tmo_cnt            <= '0;
                            state              <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (core_done) begin
                            m_data     <= core_ciphertext ^ data_q;
                            m_valid    <= 1'b1;
                            core_clear <= 1'b1;
                            ctr        <= ctr_next;
                            // The block just finished is still delivered;
                            // only further input is blocked.
                            if (&ctr[CTR_W-1:0])
                                ctr_wrap <= 1'b1;
                            state      <= S_OUT;
                        end else if (tmo_cnt == TMO_LAST) begin
                            err_timeout <= 1'b1;
                            key_ready   <= 1'b0;
                            core_clear  <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                            state   <= S_WAIT_IN;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
